// File: rtl/mic_frame_buffer.sv
// Microphone frame buffer: derives an ADC read strobe, optionally box-car averages reads,
// and stores samples in an N-deep ring that is frozen and handed out as overlapping frames.
module mic_frame_buffer #(
   parameter int N           = 256,
   parameter int W           = 12,
   parameter int CLK_FREQ    = 10000000,
   parameter int SAMPLE_RATE = 5000,
   parameter int AVG_LOG2    = 0,
   parameter int HOP         = N
) (
   input  logic                 clk_10MHz,
   input  logic                 rst,
   input  logic [W-1:0]         adc_sample,
   output logic                 frame_valid,
   input  logic                 frame_ack,
   input  logic [$clog2(N)-1:0] rd_addr,
   output logic [W-1:0]         rd_data,
   output logic                 store_strobe,
   output logic [15:0]          overrun_cnt
);

   localparam int AW  = $clog2(N);
   localparam int DIV = CLK_FREQ / SAMPLE_RATE;
   localparam int DW  = $clog2(DIV);
   localparam int AIW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam int ACW = W + AVG_LOG2;
   localparam int FW  = AW + 1;

   typedef enum logic {
      FILL,
      READY
   } state_t;

   state_t          state, state_nx;
   logic [DW-1:0]   div_cnt;
   logic            tick;
   logic [AIW-1:0]  avg_idx;
   logic [ACW-1:0]  acc;
   logic [ACW-1:0]  acc_sum;
   logic            last_read;
   logic [W-1:0]    avg_value;
   logic            store_evt;
   logic            accept;
   logic            drop;
   logic [W-1:0]    mem [N];
   logic [AW-1:0]   wr_ptr;
   logic [FW-1:0]   fill;
   logic [FW-1:0]   threshold;

   assign tick = (div_cnt == DW'(DIV - 1));

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_10MHz) begin
      if (rst) begin
         div_cnt <= '0;
      end else if (tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   // With AVG_LOG2 = 0 every read is the last of its group, so each tick stores directly.
   assign last_read = (avg_idx == AIW'((1 << AVG_LOG2) - 1));
   assign acc_sum   = acc + ACW'(adc_sample);
   assign avg_value = W'(acc_sum >> AVG_LOG2);
   assign store_evt = tick & last_read;
   assign accept    = store_evt & (state == FILL);
   assign drop      = store_evt & (state == READY);

   always_ff @(posedge clk_10MHz) begin
      if (rst) begin
         acc     <= '0;
         avg_idx <= '0;
      end else if (tick) begin
         if (last_read) begin
            acc     <= '0;
            avg_idx <= '0;
         end else begin
            acc     <= acc_sum;
            avg_idx <= avg_idx + 1'b1;
         end
      end
   end

   // NOTE: the sample RAM has no reset so it maps onto block RAM; stale words are never exposed as a frame.
   always_ff @(posedge clk_10MHz) begin
      if (accept) begin
         mem[wr_ptr] <= avg_value;
      end
   end

   // wr_ptr always points at the oldest stored word, so offsetting by it yields oldest-first order.
   always_ff @(posedge clk_10MHz) begin
      if (rst) begin
         rd_data <= '0;
      end else begin
         rd_data <= mem[wr_ptr + rd_addr];
      end
   end

   always_ff @(posedge clk_10MHz) begin
      if (rst) begin
         wr_ptr       <= '0;
         fill         <= '0;
         threshold    <= FW'(N);
         store_strobe <= 1'b0;
         overrun_cnt  <= '0;
      end else begin
         store_strobe <= accept;
         if (accept) begin
            wr_ptr <= wr_ptr + 1'b1;
            fill   <= fill + 1'b1;
         end
         if (drop && (overrun_cnt != 16'hFFFF)) begin
            overrun_cnt <= overrun_cnt + 16'd1;
         end
         if ((state == READY) && frame_ack) begin
            fill      <= '0;
            threshold <= FW'(HOP);
         end
      end
   end

   always_ff @(posedge clk_10MHz) begin
      if (rst) begin
         state <= FILL;
      end else begin
         state <= state_nx;
      end
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_nx    = state;
      frame_valid = (state == READY);
      case (state)
         FILL: begin
            if (accept && ((fill + 1'b1) == threshold)) begin
               state_nx = READY;
            end
         end
         READY: begin
            if (frame_ack) begin
               state_nx = FILL;
            end
         end
      endcase
   end

endmodule

// File: tb/tb_mic_frame_buffer.sv
// Bench for mic_frame_buffer: three instances (HOP=N, HOP=2, 4-read averaging) checked every cycle
// against a frame-level model, plus directed literal expectations for each scenario.
module tb_mic_frame_buffer;

   localparam int DIV = 10;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] adc [3];
   logic        fv  [3];
   logic        ack [3];
   logic [2:0]  ra  [3];
   logic [11:0] rdd [3];
   logic        ss  [3];
   logic [15:0] ovr [3];

   always #5 clk = ~clk;

   mic_frame_buffer #(.N(8), .W(12), .CLK_FREQ(100), .SAMPLE_RATE(10), .AVG_LOG2(0), .HOP(8)) dut_a (
      .clk_10MHz(clk), .rst(rst), .adc_sample(adc[0]), .frame_valid(fv[0]), .frame_ack(ack[0]),
      .rd_addr(ra[0]), .rd_data(rdd[0]), .store_strobe(ss[0]), .overrun_cnt(ovr[0]));

   mic_frame_buffer #(.N(8), .W(12), .CLK_FREQ(100), .SAMPLE_RATE(10), .AVG_LOG2(0), .HOP(2)) dut_b (
      .clk_10MHz(clk), .rst(rst), .adc_sample(adc[1]), .frame_valid(fv[1]), .frame_ack(ack[1]),
      .rd_addr(ra[1]), .rd_data(rdd[1]), .store_strobe(ss[1]), .overrun_cnt(ovr[1]));

   mic_frame_buffer #(.N(8), .W(12), .CLK_FREQ(100), .SAMPLE_RATE(10), .AVG_LOG2(2), .HOP(8)) dut_c (
      .clk_10MHz(clk), .rst(rst), .adc_sample(adc[2]), .frame_valid(fv[2]), .frame_ack(ack[2]),
      .rd_addr(ra[2]), .rd_data(rdd[2]), .store_strobe(ss[2]), .overrun_cnt(ovr[2]));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   function automatic int hop_of(input int i);
      return (i == 1) ? 2 : 8;
   endfunction

   function automatic int avg_of(input int i);
      return (i == 2) ? 2 : 0;
   endfunction

   // Inputs seen at the last rising edge.
   bit cap_rst = 1'b0;
   bit cap_ack [3];
   int cap_ra  [3];
   int cap_adc [3];

   initial begin
      forever begin
         @(posedge clk);
         cap_rst = rst;
         for (int i = 0; i < 3; i++) begin
            cap_ack[i] = ack[i];
            cap_ra[i]  = int'(ra[i]);
            cap_adc[i] = int'(adc[i]);
         end
      end
   end

   // Frame-level model: edges since reset, reads grouped by 2^A, the last 8 stored values.
   bit model_on = 1'b0;
   int m_edges  = 0;
   int m_ticks  = 0;
   int g_sum [3];
   int g_n   [3];
   int win   [3][8];
   bit frz   [3];
   int since [3];
   int thr   [3];
   int ovr_m [3];
   bit stb_m [3];
   int rd_m  [3];
   bit rd_chk[3];

   initial begin
      forever begin
         @(negedge clk);
         if (cap_rst) begin
            model_on = 1'b1;
            m_edges  = 0;
            m_ticks  = 0;
            for (int i = 0; i < 3; i++) begin
               g_sum[i] = 0; g_n[i] = 0; frz[i] = 1'b0; since[i] = 0; thr[i] = 8;
               ovr_m[i] = 0; stb_m[i] = 1'b0; rd_m[i] = 0; rd_chk[i] = 1'b1;
            end
         end else if (model_on) begin
            bit is_tick;
            m_edges++;
            is_tick = ((m_edges % DIV) == 0);
            for (int i = 0; i < 3; i++) begin
               bit was_frozen;
               was_frozen = frz[i];
               rd_chk[i]  = was_frozen;
               if (was_frozen) rd_m[i] = win[i][cap_ra[i]];
               stb_m[i] = 1'b0;
               if (is_tick) begin
                  g_sum[i] += cap_adc[i];
                  g_n[i]++;
                  if (g_n[i] == (2 ** avg_of(i))) begin
                     int val;
                     val = g_sum[i] / (2 ** avg_of(i));
                     g_sum[i] = 0;
                     g_n[i]   = 0;
                     if (!was_frozen) begin
                        for (int j = 0; j < 7; j++) win[i][j] = win[i][j+1];
                        win[i][7] = val;
                        since[i]++;
                        stb_m[i] = 1'b1;
                        if (since[i] == thr[i]) frz[i] = 1'b1;
                     end else if (ovr_m[i] < 65535) begin
                        ovr_m[i]++;
                     end
                  end
               end
               if (was_frozen && cap_ack[i]) begin
                  frz[i] = 1'b0; since[i] = 0; thr[i] = hop_of(i);
               end
            end
            if (is_tick) m_ticks++;
         end
         if (model_on) begin
            for (int i = 0; i < 3; i++) begin
               check($sformatf("cmp_frame_valid%0d", i), fv[i], frz[i]);
               check($sformatf("cmp_strobe%0d", i), ss[i], stb_m[i]);
               check($sformatf("cmp_overrun%0d", i), ovr[i], ovr_m[i]);
               if (rd_chk[i]) check($sformatf("cmp_rd_data%0d", i), rdd[i], rd_m[i]);
            end
         end
      end
   end

   int phase = 0;
   int c_str = 0;

   function automatic int c_val(input int ph, input int t);
      if (ph == 0) begin
         case (t)
            0: return 4;
            1: return 5;
            2: return 6;
            3: return 8;
            4, 5, 6, 7: return 4095;
            default: return (t * 97) % 4096;
         endcase
      end
      case (t)
         0: return 10;
         1: return 11;
         2: return 12;
         3: return 14;
         default: return (t * 53) % 4096;
      endcase
   endfunction

   task automatic step();
      @(negedge clk);
      #1;
      if (ss[2]) c_str++;
      adc[0] = 12'(m_ticks + 1);
      adc[1] = 12'(m_ticks + 1);
      adc[2] = 12'(c_val(phase, m_ticks));
   endtask

   task automatic do_reset();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic wait_fv(input int i, output int nstr);
      int g;
      nstr = 0;
      g    = 0;
      while (fv[i] !== 1'b1 && g < 300) begin
         step();
         g++;
         if (ss[i]) nstr++;
      end
      check($sformatf("frame_valid%0d_rise", i), fv[i], 1);
   endtask

   task automatic read_frame(input int i, input int e[8]);
      ra[i] = 3'd0;
      for (int k = 0; k < 8; k++) begin
         step();
         check($sformatf("frame%0d_addr%0d", i, k), rdd[i], e[k]);
         ra[i] = 3'(k + 1);
      end
   endtask

   task automatic release_frame(input int i);
      ack[i] = 1'b1;
      step();
      ack[i] = 1'b0;
      check($sformatf("ack_release%0d", i), fv[i], 0);
   endtask

   initial begin
      int cnt, gap, nstr, guard, na, nb;
      int exp8 [8];
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         ack[i] = 1'b0; ra[i] = 3'd0; adc[i] = 12'd0;
      end
      ra[2] = 3'd7;
      do_reset();
      c_str = 0;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("reset_fv%0d", i), fv[i], 0);
         check($sformatf("reset_strobe%0d", i), ss[i], 0);
         check($sformatf("reset_overrun%0d", i), ovr[i], 0);
         check($sformatf("reset_rd%0d", i), rdd[i], 0);
      end

      // Strobe timing: 11th cycle after reset release, then every 10 cycles.
      cnt = 1;
      while (!ss[0] && cnt < 100) begin step(); cnt++; end
      check("first_strobe_cycle", cnt, 11);
      gap = 0;
      do begin step(); gap++; end while (!ss[0] && gap < 100);
      check("strobe_spacing", gap, 10);
      wait_fv(0, nstr);
      check("strobes_to_first_frame", nstr, 6);
      check("fv_with_8th_strobe", ss[0], 1);
      check("hop2_first_frame_at_n", fv[1], 1);
      check("avg_strobe_count", c_str, 2);
      check("avg_4_5_6_8", rdd[2], 5);
      exp8 = '{1, 2, 3, 4, 5, 6, 7, 8};
      read_frame(0, exp8);
      check("avg_4095x4", rdd[2], 4095);
      release_frame(0);

      // HOP=2 instance left frozen for five store periods.
      guard = 0;
      while (ovr[1] != 16'd5 && guard < 200) begin step(); guard++; end
      check("overrun_after_5_periods", ovr[1], 5);
      release_frame(1);
      wait_fv(1, nstr);
      check("hop2_stores_to_frame", nstr, 2);
      check("hop2_overrun_held", ovr[1], 5);
      exp8 = '{3, 4, 5, 6, 7, 8, 14, 15};
      read_frame(1, exp8);
      release_frame(1);

      wait_fv(0, nstr);
      check("second_frame_overrun", ovr[0], 0);
      exp8 = '{9, 10, 11, 12, 13, 14, 15, 16};
      read_frame(0, exp8);
      release_frame(0);

      // Reset mid-frame and with two reads of an averaging group pending.
      guard = 0;
      while (m_ticks != 22 && guard < 400) begin step(); guard++; end
      check("reached_mid_group", m_ticks, 22);
      step();
      phase = 1;
      do_reset();
      c_str = 0;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("midrun_reset_fv%0d", i), fv[i], 0);
         check($sformatf("midrun_reset_strobe%0d", i), ss[i], 0);
         check($sformatf("midrun_reset_overrun%0d", i), ovr[i], 0);
         check($sformatf("midrun_reset_rd%0d", i), rdd[i], 0);
      end

      // Ack held during FILL is ignored; threshold is back to N for both HOP settings.
      na = 0; nb = 0; cnt = 0;
      ack[0] = 1'b1;
      while (fv[0] !== 1'b1 && cnt < 200) begin
         step();
         cnt++;
         if (ss[0]) na++;
         if (ss[1]) nb++;
         if (cnt == 50) begin
            check("avg_no_stale_partial", rdd[2], 11);
            ack[0] = 1'b0;
         end
      end
      check("fill_ack_ignored_stores", na, 8);
      check("hop2_threshold_back_to_n", nb, 8);
      check("hop2_frame_after_reset", fv[1], 1);

      // Ack on the same edge as a store: store is dropped and counted once.
      repeat (9) step();
      ack[0] = 1'b1;
      step();
      ack[0] = 1'b0;
      check("same_edge_fv", fv[0], 0);
      check("same_edge_no_strobe", ss[0], 0);
      check("same_edge_overrun", ovr[0], 1);
      repeat (10) step();
      check("post_release_store", ss[0], 1);
      check("post_release_overrun", ovr[0], 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mic_frame_buffer.md
Name: mic_frame_buffer

Overview:
Parametrised successor to the single-channel microphone sample shifter. It derives its own sample strobe from the 10 MHz clock and optionally box-car averages 2^AVG_LOG2 ADC reads per stored sample. Samples go into an N-deep ring buffer. Overlapping frames (hop HOP) are handed to the downstream FFT/visualiser through a valid/ack handshake plus a random-access, oldest-first read port. The buffer is frozen while a frame is pending, and dropped samples are counted.

Parameters:
N, 256, frame length in samples; power of two, 2..4096
W, 12, ADC sample width in bits
CLK_FREQ, 10000000, clk_10MHz frequency in Hz
SAMPLE_RATE, 5000, ADC read rate in Hz; DIV = CLK_FREQ/SAMPLE_RATE, integer division, DIV >= 2
AVG_LOG2, 0, log2 of ADC reads averaged per stored sample; 0..4
HOP, N, new stored samples required between frames; 1..N

Ports:
clk_10MHz  in  1  sole clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
adc_sample  in  W  current ADC conversion result, sampled only on internal read ticks
frame_valid  out  1  a complete frame is frozen and readable
frame_ack  in  1  consumer releases the frame; only effective while frame_valid=1
rd_addr  in  log2(N)  frame index; 0 = oldest sample, N-1 = newest
rd_data  out  W  sample at rd_addr, registered
store_strobe  out  1  one-cycle pulse on every accepted write into the buffer
overrun_cnt  out  16  stored samples dropped while frozen; saturating

Behaviour:
- Reset (rst=1 at an edge): divider count, average accumulator, average index, write pointer, fill count, frame_valid, store_strobe, rd_data and overrun_cnt all go to 0. Next frame threshold = N. RAM contents are not cleared. Reset applied mid-frame or mid-average discards that frame or partial sum without any output.
- Divider: counts 0..DIV-1 and wraps. tick=1 in the cycle where count==DIV-1. The first tick falls DIV cycles after reset deasserts.
- Averaging: on each tick, avg_idx increments modulo 2^AVG_LOG2.
  - If it is not the last read of the group: acc <= acc + adc_sample.
  - If it is the last read: store value = (acc + adc_sample) >> AVG_LOG2 (truncating), and acc <= 0.
  - acc width is W+AVG_LOG2; no overflow is possible.
  - With AVG_LOG2=0, every tick is a store of adc_sample.
- Store, when frame_valid=0 at that edge:
  - mem[wr_ptr] <= value; wr_ptr <= wr_ptr+1 modulo N.
  - fill <= fill+1; store_strobe=1 for exactly the following cycle.
- Store, when frame_valid=1:
  - Value dropped; RAM, wr_ptr and fill unchanged; no store_strobe.
  - overrun_cnt <= min(overrun_cnt+1, 16'hFFFF).
- Frame FSM, FILL -> READY:
  - FILL is the state after reset.
  - When an accepted store makes fill == threshold, frame_valid=1 from the next cycle.
- Frame FSM, READY:
  - frame_ack=1 at an edge -> frame_valid=0 next cycle, fill <= 0, threshold <= HOP, return to FILL.
  - frame_ack while in FILL is ignored.
  - A store on the same edge as the ack is dropped and counted, because the buffer is still frozen at that edge.
- Read port: rd_data <= mem[(wr_ptr + rd_addr) mod N] at every edge, giving 1-cycle latency.
  - Reads are always enabled.
  - Contents are guaranteed coherent only while frame_valid=1.
  - Write and read of the same word in one cycle returns the old data.
- Frame semantics: each frame is the N most recent stored samples, oldest first. Consecutive frames overlap by N-HOP samples.
- overrun_cnt is cleared only by rst.

Test Plan:
1. CLK_FREQ=100, SAMPLE_RATE=10 (DIV=10), N=8, HOP=8, AVG_LOG2=0, adc_sample = ramp incremented once per tick from 1 -> first store_strobe 11 cycles after reset release, strobes 10 cycles apart. frame_valid rises one cycle after the 8th store. Reading addr 0..7 returns 1..8, each one cycle after its address.
2. Same config, ack the first frame immediately -> frame_valid low next cycle. The second frame after 8 more stores reads 9..16. overrun_cnt=0.
3. N=8, HOP=2, never ack for 5 store periods, then ack -> overrun_cnt=5. The next frame needs 2 further stores and reads 3..8 followed by the two new samples. The wrap-around of wr_ptr is exercised.
4. AVG_LOG2=2, adc_sample sequence 4,5,6,8 per tick -> a single stored value of 5 (23>>2), with store_strobe only on the 4th tick. A sequence of 4095 ×4 stores 4095.
5. Assert rst for one cycle midway through filling the 2nd frame and midway through an averaging group -> all outputs 0. The threshold returns to N; no frame appears until N fresh stores. The stale partial sum does not leak into the first stored value.
6. frame_ack held high during FILL and on the same edge as a store in READY -> the FILL ack has no effect. The same-edge store is dropped and overrun_cnt increments by exactly 1.
